lfsr_sampler: RTL and testbench



---
 rtl/lfsr_pkg.sv | 13 +
 rtl/lfsr_sampler_if.sv | 11 +
 rtl/rnd_fifo.sv | 63 ++++++
 rtl/lfsr_sampler.sv | 73 +++++++
 tb/tb_lfsr_sampler.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/lfsr_pkg.sv
// Shared constants for the LFSR generator and its downstream sampler.
package lfsr_pkg;
    localparam int              LFSR_W       = 10;
    localparam logic [9:0]      LFSR_SEED    = 10'h26E;
    localparam int              SAMPLE_LIMIT = 1000;
    localparam int              SAMPLE_DEPTH = 4;
    localparam int              CNT_W        = 16;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction
endpackage

// File: rtl/lfsr_sampler_if.sv
// Valid/ready stream carrying accepted random words out of the sampler.
interface lfsr_sampler_if #(
    parameter int WIDTH = 10
);
    logic [WIDTH-1:0] rnd_data;
    logic             rnd_valid;
    logic             rnd_ready;

    modport master (output rnd_data, output rnd_valid, input rnd_ready);
    modport slave  (input rnd_data, input rnd_valid, output rnd_ready);
endinterface

// File: rtl/rnd_fifo.sv
// Synchronous first-word-fall-through FIFO; head is a pure function of registered state.
module rnd_fifo #(
    parameter int W     = 10,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic          valid,
    output logic [CW-1:0] count
);
    logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           count_q, count_d;
    logic                    do_push, do_pop;

    // Guard internally as well so the count can never over- or underflow.
    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && ((count_q < CW'(DEPTH)) || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign valid = (count_q != '0);
    assign count = count_q;
endmodule

// File: rtl/lfsr_sampler.sv
// Samples the LFSR word, keeps values below LIMIT in a small FIFO and counts periods and drops.
module lfsr_sampler
    import lfsr_pkg::*;
#(
    parameter int WIDTH = LFSR_W,
    parameter int LIMIT = SAMPLE_LIMIT,
    parameter int DEPTH = SAMPLE_DEPTH,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] lfsr_q,
    input  logic             lfsr_tick,
    input  logic             en,
    lfsr_sampler_if.master   rnd,
    output logic [CW-1:0]    fifo_count,
    output logic [CNT_W-1:0] period_cnt,
    output logic [CNT_W-1:0] drop_cnt
);
    // One extra bit lets LIMIT = 2**WIDTH accept every word.
    localparam logic [WIDTH:0] LIMIT_CMP = (WIDTH + 1)'(LIMIT);

    logic [WIDTH-1:0] s_data_q, s_data_d;
    logic             s_valid_q, s_valid_d;
    logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             in_range, push, pop, fifo_valid;
    logic [WIDTH-1:0] fifo_rdata;

    assign in_range = s_valid_q && ({1'b0, s_data_q} < LIMIT_CMP);
    assign pop      = fifo_valid && rnd.rnd_ready;
    assign push     = in_range && ((fifo_count < CW'(DEPTH)) || pop);

    always_comb begin
        s_valid_d    = en;
        s_data_d     = en ? lfsr_q : s_data_q;
        period_cnt_d = lfsr_tick ? sat_inc(period_cnt_q) : period_cnt_q;
        drop_cnt_d   = (in_range && !push) ? sat_inc(drop_cnt_q) : drop_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_valid_q    <= 1'b0;
            s_data_q     <= '0;
            period_cnt_q <= '0;
            drop_cnt_q   <= '0;
        end else begin
            s_valid_q    <= s_valid_d;
            s_data_q     <= s_data_d;
            period_cnt_q <= period_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    rnd_fifo #(
        .W     (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (s_data_q),
        .pop   (pop),
        .rdata (fifo_rdata),
        .valid (fifo_valid),
        .count (fifo_count)
    );

    assign rnd.rnd_data  = fifo_rdata;
    assign rnd.rnd_valid = fifo_valid;
    assign period_cnt    = period_cnt_q;
    assign drop_cnt      = drop_cnt_q;
endmodule

// File: tb/tb_lfsr_sampler.sv
// Bench for lfsr_sampler: directed table, hand sequences and random stimulus vs a queue model.
module tb_lfsr_sampler;
    logic       clk = 1'b0;
    logic       rst, en, tick, rdy;
    logic [9:0] lfsr;
    logic [2:0] cnt1, cnt2;
    logic [15:0] per1, per2, drop1, drop2;
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    lfsr_sampler_if #(.WIDTH(10)) rif1 ();
    lfsr_sampler_if #(.WIDTH(10)) rif2 ();
    assign rif1.rnd_ready = rdy;
    assign rif2.rnd_ready = rdy;

    lfsr_sampler #(.WIDTH(10), .LIMIT(1000), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .lfsr_q(lfsr), .lfsr_tick(tick), .en(en),
        .rnd(rif1), .fifo_count(cnt1), .period_cnt(per1), .drop_cnt(drop1));

    lfsr_sampler #(.WIDTH(10), .LIMIT(1024), .DEPTH(4)) dut2 (
        .clk(clk), .rst(rst), .lfsr_q(lfsr), .lfsr_tick(tick), .en(en),
        .rnd(rif2), .fifo_count(cnt2), .period_cnt(per2), .drop_cnt(drop2));

    // Reference model: a queue per DUT plus plain integer counters.
    int mq1[$];
    int mq2[$];
    bit m_sv;
    int m_sd, m_per, m_drop1, m_drop2;

    typedef struct {
        logic       en;
        logic [9:0] d;
        logic       rdy;
        logic       ev;
        logic [9:0] ed;
        int         ec;
        int         edrop;
    } vec_t;
    vec_t tbl[16];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_step(input logic r, e, input logic [9:0] d, input logic rd, tk);
        bit full1, full2, pop1, pop2;
        if (r) begin
            mq1.delete(); mq2.delete();
            m_sv = 0; m_sd = 0; m_per = 0; m_drop1 = 0; m_drop2 = 0;
        end else begin
            full1 = (mq1.size() == 4);
            full2 = (mq2.size() == 4);
            pop1  = (mq1.size() > 0) && rd;
            pop2  = (mq2.size() > 0) && rd;
            if (pop1) void'(mq1.pop_front());
            if (pop2) void'(mq2.pop_front());
            if (m_sv && m_sd < 1000) begin
                if (!full1 || pop1) mq1.push_back(m_sd);
                else if (m_drop1 < 65535) m_drop1++;
            end
            if (m_sv && m_sd < 1024) begin
                if (!full2 || pop2) mq2.push_back(m_sd);
                else if (m_drop2 < 65535) m_drop2++;
            end
            if (tk && m_per < 65535) m_per++;
            m_sv = e;
            if (e) m_sd = int'(d);
        end
    endtask

    task automatic check_model();
        chk("valid1", int'(rif1.rnd_valid), int'(mq1.size() > 0));
        chk("count1", int'(cnt1), mq1.size());
        if (mq1.size() > 0) chk("data1", int'(rif1.rnd_data), mq1[0]);
        chk("period1", int'(per1), m_per);
        chk("drop1", int'(drop1), m_drop1);
        chk("valid2", int'(rif2.rnd_valid), int'(mq2.size() > 0));
        chk("count2", int'(cnt2), mq2.size());
        if (mq2.size() > 0) chk("data2", int'(rif2.rnd_data), mq2[0]);
        chk("period2", int'(per2), m_per);
        chk("drop2", int'(drop2), m_drop2);
    endtask

    task automatic cyc(input logic r, e, input logic [9:0] d, input logic rd, tk);
        rst = r; en = e; lfsr = d; rdy = rd; tick = tk;
        @(posedge clk);
        model_step(r, e, d, rd, tk);
        #1;
        check_model();
    endtask

    initial begin
        tbl[0]  = '{1'b1, 10'h26E, 1'b0, 1'b0, 10'h000, 0, 0};
        tbl[1]  = '{1'b1, 10'h0DC, 1'b0, 1'b1, 10'h26E, 1, 0};
        tbl[2]  = '{1'b1, 10'h1B9, 1'b0, 1'b1, 10'h26E, 2, 0};
        tbl[3]  = '{1'b1, 10'h373, 1'b0, 1'b1, 10'h26E, 3, 0};
        tbl[4]  = '{1'b1, 10'h2E6, 1'b0, 1'b1, 10'h26E, 4, 0};
        tbl[5]  = '{1'b0, 10'h000, 1'b0, 1'b1, 10'h26E, 4, 1};
        tbl[6]  = '{1'b0, 10'h000, 1'b0, 1'b1, 10'h26E, 4, 1};
        tbl[7]  = '{1'b0, 10'h000, 1'b1, 1'b1, 10'h0DC, 3, 1};
        tbl[8]  = '{1'b0, 10'h000, 1'b1, 1'b1, 10'h1B9, 2, 1};
        tbl[9]  = '{1'b0, 10'h000, 1'b1, 1'b1, 10'h373, 1, 1};
        tbl[10] = '{1'b0, 10'h000, 1'b1, 1'b0, 10'h000, 0, 1};
        tbl[11] = '{1'b1, 10'h3E8, 1'b1, 1'b0, 10'h000, 0, 1};
        tbl[12] = '{1'b1, 10'h3FF, 1'b1, 1'b0, 10'h000, 0, 1};
        tbl[13] = '{1'b1, 10'h3E7, 1'b1, 1'b0, 10'h000, 0, 1};
        tbl[14] = '{1'b0, 10'h000, 1'b1, 1'b1, 10'h3E7, 1, 1};
        tbl[15] = '{1'b0, 10'h000, 1'b1, 1'b0, 10'h000, 0, 1};

        // Reset state
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("rst_valid", int'(rif1.rnd_valid), 0);
        chk("rst_data", int'(rif1.rnd_data), 0);
        chk("rst_count", int'(cnt1), 0);
        chk("rst_period", int'(per1), 0);
        chk("rst_drop", int'(drop1), 0);

        // Fill, overflow drop, drain, range reject
        for (int i = 0; i < 16; i++) begin
            cyc(0, tbl[i].en, tbl[i].d, tbl[i].rdy, 0);
            chk($sformatf("tbl%0d_valid", i), int'(rif1.rnd_valid), int'(tbl[i].ev));
            chk($sformatf("tbl%0d_count", i), int'(cnt1), tbl[i].ec);
            chk($sformatf("tbl%0d_drop", i), int'(drop1), tbl[i].edrop);
            if (tbl[i].ev) chk($sformatf("tbl%0d_data", i), int'(rif1.rnd_data), int'(tbl[i].ed));
        end

        // Full FIFO with simultaneous push and pop every cycle
        for (int i = 0; i < 5; i++) cyc(0, 1, 10'($urandom_range(0, 999)), 0, 0);
        chk("full_count", int'(cnt1), 4);
        for (int i = 0; i < 20; i++) begin
            cyc(0, 1, 10'($urandom_range(0, 999)), 1, 0);
            chk("pp_count", int'(cnt1), 4);
            chk("pp_drop", int'(drop1), 1);
        end
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, 0);

        // Two-edge latency on an empty FIFO
        cyc(0, 1, 10'h155, 0, 0);
        chk("lat_edge1_valid", int'(rif1.rnd_valid), 0);
        cyc(0, 0, 0, 0, 0);
        chk("lat_edge2_valid", int'(rif1.rnd_valid), 1);
        chk("lat_edge2_data", int'(rif1.rnd_data), 'h155);
        cyc(0, 0, 0, 1, 0);
        chk("lat_pop_valid", int'(rif1.rnd_valid), 0);

        // Random traffic
        for (int i = 0; i < 400; i++)
            cyc(0, 1'($urandom), 10'($urandom_range(0, 1023)), 1'($urandom), ($urandom_range(0, 7) == 0));

        // Reset with 3 buffered entries and one in flight
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 10'(100 + i), 0, 0);
        chk("mid_pre_count", int'(cnt1), 3);
        cyc(1, 1, 10'h0AA, 0, 0);
        chk("mid_valid", int'(rif1.rnd_valid), 0);
        chk("mid_count", int'(cnt1), 0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 1, 0);
            chk("mid_flight_valid", int'(rif1.rnd_valid), 0);
        end

        // Period counter and saturation
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1);
        chk("period3", int'(per1), 3);
        for (int i = 0; i < 65537; i++) cyc(0, 0, 0, 0, 1);
        chk("period_sat", int'(per1), 'hFFFF);
        chk("period_sat2", int'(per2), 'hFFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
